// File: rtl/mac_beams_pkg.sv
// Shared types and complex-arithmetic helpers for the beam MAC.
// Samples are packed {real, imag}, each a signed half-word.
package mac_beams_pkg;

    localparam int HW = 16;
    localparam int PW = 2*HW + 1;

    typedef struct packed {
        logic signed [PW-1:0] re;
        logic signed [PW-1:0] im;
    } cprod_t;

    function automatic logic signed [HW-1:0] cre(
        input logic [2*HW-1:0] s
    );
        return s[2*HW-1:HW];
    endfunction

    function automatic logic signed [HW-1:0] cim(
        input logic [2*HW-1:0] s
    );
        return s[HW-1:0];
    endfunction

    // Full-precision a*c without conjugation.
    function automatic cprod_t cmul(
        input logic [2*HW-1:0] a,
        input logic [2*HW-1:0] c
    );
        logic signed [PW-1:0] ar, ai, cr, ci;
        cprod_t p;
        ar = PW'(cre(a));
        ai = PW'(cim(a));
        cr = PW'(cre(c));
        ci = PW'(cim(c));
        p.re = ar*cr - ai*ci;
        p.im = ar*ci + ai*cr;
        return p;
    endfunction

endpackage

// File: rtl/mac_beams_if.sv
// One half-beam lane: antenna samples and code word in,
// accumulated complex dot product out.
interface mac_beams_if #(
    parameter int ANT = 32,
    parameter int IW  = 32,
    parameter int OW  = 48
);
    logic [ANT*IW-1:0] ants;
    logic [ANT*IW-1:0] cw;
    logic [2*OW-1:0]   sum;

    modport master (output ants, output cw, input sum);
    modport slave  (input ants, input cw, output sum);
endinterface

// File: rtl/mac_ants_dot.sv
// ANT-antenna complex multiply followed by a registered
// binary adder tree; one half of one beam.
module mac_ants_dot
    import mac_beams_pkg::*;
#(
    parameter int ANT = 32,
    parameter int IW  = 32,
    parameter int OW  = 48
) (
    input  logic        i_clk,
    input  logic        reset,
    mac_beams_if.slave  bus
);

    localparam int NN = 2*ANT - 1;

    logic signed [OW-1:0] p_re [ANT];
    logic signed [OW-1:0] p_im [ANT];
    logic signed [OW-1:0] t_re [NN];
    logic signed [OW-1:0] t_im [NN];

    // Per-antenna products, sign-extended to accumulator width.
    always_comb begin
        cprod_t p;
        p = '0;
        for (int a = 0; a < ANT; a++) begin
            p = cmul(bus.ants[IW*a +: IW], bus.cw[IW*a +: IW]);
            p_re[a] = OW'($signed(p.re));
            p_im[a] = OW'($signed(p.im));
        end
    end

    // Heap-ordered tree: leaves hold products, node j sums
    // children 2j+1 and 2j+2, root at index 0.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            for (int j = 0; j < NN; j++) begin
                t_re[j] <= '0;
                t_im[j] <= '0;
            end
        end else begin
            for (int j = 0; j < ANT-1; j++) begin
                t_re[j] <= t_re[2*j+1] + t_re[2*j+2];
                t_im[j] <= t_im[2*j+1] + t_im[2*j+2];
            end
            for (int a = 0; a < ANT; a++) begin
                t_re[ANT-1+a] <= p_re[a];
                t_im[ANT-1+a] <= p_im[a];
            end
        end
    end

    assign bus.sum = {t_re[0], t_im[0]};

endmodule

// File: rtl/mac_beams.sv
// Multi-beam complex MAC: odd and even antenna halves per
// beam are reduced separately, then combined.
module mac_beams
    import mac_beams_pkg::*;
#(
    parameter int BEAM = 16,
    parameter int ANT  = 32,
    parameter int IW   = 32,
    parameter int OW   = 48
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [ANT*IW-1:0]             i_ants_data_even,
    input  logic [ANT*IW-1:0]             i_ants_data_odd,
    input  logic                          i_rvalid,
    input  logic [BEAM-1:0][ANT*IW-1:0]   i_code_word_even,
    input  logic [BEAM-1:0][ANT*IW-1:0]   i_code_word_odd,
    output logic [OW-1:0]                 o_sum_data
);

    localparam int L = $clog2(ANT);

    logic [BEAM-1:0][2*OW-1:0] odd_sum_data;
    logic [BEAM-1:0][2*OW-1:0] even_sum_data;
    logic [BEAM-1:0][2*OW-1:0] ants_sum;
    logic [L+1:0]              vld;
    logic                      ants_valid;

    for (genvar b = 0; b < BEAM; b++) begin : g_beam
        mac_beams_if #(.ANT(ANT), .IW(IW), .OW(OW)) odd_if ();
        mac_beams_if #(.ANT(ANT), .IW(IW), .OW(OW)) even_if ();

        assign odd_if.ants  = i_ants_data_odd;
        assign odd_if.cw    = i_code_word_odd[b];
        assign even_if.ants = i_ants_data_even;
        assign even_if.cw   = i_code_word_even[b];

        mac_ants_dot #(.ANT(ANT), .IW(IW), .OW(OW)) u_odd (
            .i_clk (i_clk),
            .reset (i_reset),
            .bus   (odd_if.slave)
        );

        mac_ants_dot #(.ANT(ANT), .IW(IW), .OW(OW)) u_even (
            .i_clk (i_clk),
            .reset (i_reset),
            .bus   (even_if.slave)
        );

        assign odd_sum_data[b]  = odd_if.sum;
        assign even_sum_data[b] = even_if.sum;
    end

    // Combine halves; real and imag wrap independently.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ants_sum <= '0;
        end else begin
            for (int b = 0; b < BEAM; b++) begin
                ants_sum[b] <= {
                    odd_sum_data[b][2*OW-1:OW]
                        + even_sum_data[b][2*OW-1:OW],
                    odd_sum_data[b][OW-1:0]
                        + even_sum_data[b][OW-1:0]
                };
            end
        end
    end

    // Sample qualifier travels with the data but gates nothing.
    always_ff @(posedge i_clk) begin
        if (i_reset) vld <= '0;
        else         vld <= {vld[L:0], i_rvalid};
    end

    assign ants_valid = vld[L+1];
    assign o_sum_data = ants_sum[0][2*OW-1:OW];

endmodule

// File: tb/tb_mac_beams.sv
// Randomised and directed bench for mac_beams against a
// plain-arithmetic dot-product model with latency windows.
module tb_mac_beams;

    localparam int BEAM = 16;
    localparam int ANT  = 32;
    localparam int IW   = 32;
    localparam int OW   = 48;
    localparam int HW   = IW/2;
    localparam int MAXE = 512;
    localparam int LH   = 5;
    localparam int LC   = 6;

    logic                        i_clk = 1'b0;
    logic                        i_reset;
    logic                        i_rvalid;
    logic [ANT*IW-1:0]           ae, ao;
    logic [BEAM-1:0][ANT*IW-1:0] ce, co;
    logic [OW-1:0]               o_sum_data;

    always #5 i_clk = ~i_clk;

    mac_beams #(.BEAM(BEAM), .ANT(ANT), .IW(IW), .OW(OW)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_ants_data_even (ae),
        .i_ants_data_odd  (ao),
        .i_rvalid         (i_rvalid),
        .i_code_word_even (ce),
        .i_code_word_odd  (co),
        .o_sum_data       (o_sum_data)
    );

    mac_beams_if #(.ANT(ANT), .IW(IW), .OW(OW)) probe ();
    assign probe.ants = ao;
    assign probe.cw   = co[0];
    assign probe.sum  = dut.odd_sum_data[0];

    int errors = 0;
    int checks = 0;
    int e = 0;

    bit     rst_q    [MAXE];
    longint m_odd_re [MAXE][BEAM];
    longint m_odd_im [MAXE][BEAM];
    longint m_evn_re [MAXE][BEAM];
    longint m_evn_im [MAXE][BEAM];

    task automatic check(
        input string           tag,
        input logic [2*OW-1:0] got,
        input logic [2*OW-1:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void dot(
        input  logic [ANT*IW-1:0] ants,
        input  logic [ANT*IW-1:0] cw,
        output longint            re,
        output longint            im
    );
        longint ar, ai, cr, ci;
        re = 0;
        im = 0;
        for (int a = 0; a < ANT; a++) begin
            ar = longint'($signed(ants[IW*a+HW +: HW]));
            ai = longint'($signed(ants[IW*a    +: HW]));
            cr = longint'($signed(cw[IW*a+HW +: HW]));
            ci = longint'($signed(cw[IW*a    +: HW]));
            re += ar*cr - ai*ci;
            im += ar*ci + ai*cr;
        end
    endfunction

    function automatic bit zeroed(input int k, input int lat);
        for (int j = k - lat; j <= k; j++)
            if (j < 0 || rst_q[j]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [OW-1:0] w(input longint v);
        return v[OW-1:0];
    endfunction

    task automatic step();
        int b;
        int s;
        logic [2*OW-1:0] xo, xe, xs, x0;
        if (e >= MAXE) begin
            $display("FAIL budget: edge %0d beyond model depth %0d",
                     e, MAXE);
            $fatal(1, "model depth exhausted");
        end
        rst_q[e] = i_reset;
        for (int k = 0; k < BEAM; k++) begin
            dot(ao, co[k], m_odd_re[e][k], m_odd_im[e][k]);
            dot(ae, ce[k], m_evn_re[e][k], m_evn_im[e][k]);
        end
        @(posedge i_clk);
        #1;
        b = $urandom_range(BEAM-1);
        xo = '0;
        xe = '0;
        x0 = '0;
        xs = '0;
        if (!zeroed(e, LH)) begin
            s  = e - LH;
            xo = {w(m_odd_re[s][b]), w(m_odd_im[s][b])};
            xe = {w(m_evn_re[s][b]), w(m_evn_im[s][b])};
            x0 = {w(m_odd_re[s][0]), w(m_odd_im[s][0])};
        end
        if (!zeroed(e, LC)) begin
            s  = e - LC;
            xs = {w(m_odd_re[s][b] + m_evn_re[s][b]),
                  w(m_odd_im[s][b] + m_evn_im[s][b])};
        end
        check("odd_sum",  dut.odd_sum_data[b],  xo);
        check("even_sum", dut.even_sum_data[b], xe);
        check("ants_sum", dut.ants_sum[b],      xs);
        check("probe",    probe.sum,            x0);
        if (zeroed(e, LC)) begin
            check("o_sum", {{OW{1'b0}}, o_sum_data}, '0);
        end else begin
            s = e - LC;
            check("o_sum", {{OW{1'b0}}, o_sum_data},
                  {{OW{1'b0}}, w(m_odd_re[s][0] + m_evn_re[s][0])});
        end
        e++;
    endtask

    task automatic set_ant(input logic [HW-1:0] r, input logic [HW-1:0] i);
        for (int a = 0; a < ANT; a++) begin
            ao[IW*a +: IW] = {r, i};
            ae[IW*a +: IW] = {r, i};
        end
    endtask

    task automatic set_cw(input logic [HW-1:0] r, input logic [HW-1:0] i);
        for (int b = 0; b < BEAM; b++)
            for (int a = 0; a < ANT; a++) begin
                co[b][IW*a +: IW] = {r, i};
                ce[b][IW*a +: IW] = {r, i};
            end
    endtask

    initial begin
        i_reset  = 1'b1;
        i_rvalid = 1'b0;
        ae = '0;
        ao = '0;
        ce = '0;
        co = '0;
        repeat (3) step();
        check("rst_osum", {{OW{1'b0}}, o_sum_data}, '0);
        check("rst_ants", dut.ants_sum[0], '0);

        // unit samples and code words
        i_reset  = 1'b0;
        i_rvalid = 1'b1;
        set_ant(16'd1, 16'd0);
        set_cw(16'd1, 16'd0);
        repeat (8) step();
        check("unit_ants", dut.ants_sum[5], {48'd64, 48'd0});
        check("unit_odd",  dut.odd_sum_data[9], {48'd32, 48'd0});

        // single odd antenna
        ao = '0;
        ae = '0;
        ce = '0;
        co = '0;
        ao[IW-1:0] = {16'd3, 16'd4};
        for (int b = 0; b < BEAM; b++)
            co[b][IW-1:0] = {16'd2, 16'hFFFF};
        repeat (8) step();
        check("one_odd",  dut.odd_sum_data[2], {48'd10, 48'd5});
        check("one_even", dut.even_sum_data[2], '0);
        check("one_osum", {{OW{1'b0}}, o_sum_data}, {48'd0, 48'd10});

        // most negative corner
        set_ant(16'h8000, 16'h8000);
        set_cw(16'h8000, 16'h8000);
        repeat (8) step();
        check("neg_ants", dut.ants_sum[1],
              {48'd0, 48'd137438953472});

        // ramp with a one-cycle reset and valid dropped late
        set_cw(16'd1, 16'd0);
        for (int i = 0; i < 26; i++) begin
            set_ant(HW'(i), 16'd0);
            i_reset  = (i == 12);
            i_rvalid = (i < 16);
            step();
            if (i == 12)
                check("ramp_rst", {{OW{1'b0}}, o_sum_data}, '0);
            if (i >= 6 && (i < 12 || i > 18))
                check("ramp", {{OW{1'b0}}, o_sum_data},
                      {{OW{1'b0}}, OW'(64*(i-6))});
        end

        // random traffic with sporadic resets
        for (int i = 0; i < 120; i++) begin
            for (int a = 0; a < ANT; a++) begin
                ao[IW*a +: IW] = $urandom;
                ae[IW*a +: IW] = $urandom;
            end
            for (int b = 0; b < BEAM; b++)
                for (int a = 0; a < ANT; a++) begin
                    co[b][IW*a +: IW] = $urandom;
                    ce[b][IW*a +: IW] = $urandom;
                end
            i_rvalid = 1'($urandom_range(1));
            i_reset  = ($urandom_range(39) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_beams.md
MAC_BEAMS -- requirements
Module: mac_beams

Interface
REQ-001 Parameter BEAM, default 16, number of beams (code words) computed in parallel.
REQ-002 Parameter ANT, default 32, antennas per half (odd/even); power of two.
REQ-003 Parameter IW, default 32, packed complex sample width: [IW-1:IW/2] = real, [IW/2-1:0] = imag, both signed two's complement.
REQ-004 Parameter OW, default 48, width of one real or imaginary accumulated result.
REQ-005 i_clk  input  1  sole clock; all logic on rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_ants_data_even  input  ANT*IW  even-antenna samples; antenna a at [IW*a +: IW].
REQ-008 i_ants_data_odd  input  ANT*IW  odd-antenna samples, same packing.
REQ-009 i_rvalid  input  1  input-sample qualifier.
REQ-010 i_code_word_even  input  [BEAM-1:0][ANT*IW-1:0]  per-beam even code word; antenna a at [IW*a +: IW].
REQ-011 i_code_word_odd  input  [BEAM-1:0][ANT*IW-1:0]  per-beam odd code word, same packing.
REQ-012 o_sum_data  output  OW  real part of combined beam-0 sum.

Function
REQ-013 Per beam b and antenna a, the block SHALL form the full-precision complex product ant[a] * cw[b][a] (no conjugation): re = ar*cr - ai*ci, im = ar*ci + ai*cr.
REQ-014 Per beam, products over all ANT odd antennas SHALL be summed into odd_sum_data[b] and over all ANT even antennas into even_sum_data[b]; each is 2*OW bits, real at [2*OW-1:OW], imag at [OW-1:0].
REQ-015 ants_sum[b] SHALL equal odd_sum_data[b] + even_sum_data[b], real and imaginary added independently.
REQ-016 All intermediate values SHALL be sign-extended to OW before addition; final results wrap modulo 2^OW (no saturation); OW=48 never overflows for 16-bit inputs and ANT<=256.
REQ-017 Pipeline: one product register stage, log2(ANT) registered adder-tree stages, then one odd+even combine stage.
REQ-018 odd_sum_data/even_sum_data SHALL reflect inputs sampled 1+log2(ANT) cycles earlier (6 for ANT=32); ants_sum 2+log2(ANT) (7); o_sum_data = ants_sum[0] real part, same latency.
REQ-019 Pipeline SHALL advance every cycle regardless of i_rvalid; i_rvalid is delayed alongside the data as internal valid and does not gate computation.
REQ-020 Code-word inputs SHALL be sampled every cycle with the antenna data (no internal code-word storage).
REQ-021 Internal arrays odd_sum_data, even_sum_data, ants_sum SHALL exist with exactly these names and layouts ([BEAM-1:0][2*OW-1:0]) for hierarchical probing.

Reset
REQ-022 While i_reset=1 at a clock edge, all pipeline registers, odd_sum_data, even_sum_data, ants_sum and o_sum_data SHALL become 0.
REQ-023 After i_reset falls, outputs SHALL be zero-fed pipeline results until the first post-reset sample reaches the output at the REQ-018 latency.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight data.

Structure
REQ-025 A shared package SHALL hold the complex half-width (IW/2) constant, the real/imag field-extraction helpers and the complex-multiply function.
REQ-026 One sub-module, mac_ants_dot (ANT-antenna complex multiply plus registered adder tree, one half, one beam), SHALL be instantiated 2*BEAM times; the top adds the odd/even results.

Verification
REQ-027 All ant=(1,0), all cw=(1,0), both halves -> after 7 cycles ants_sum[b] re=64, im=0 for all b; odd/even each re=32 after 6 cycles.
REQ-028 Odd ant[0]=(3,4), odd cw[b][0]=(2,-1), all else 0 -> odd_sum_data[b] re=10, im=5; even_sum_data=0; o_sum_data=10.
REQ-029 All ant=(-32768,-32768), all cw=(-32768,-32768) -> per product re=0, im=2^31; ants_sum im=64*2^31=2^37, re=0 (no overflow, sign correct).
REQ-030 Ramp ant[a].re = cycle index per cycle, cw=(1,0) -> o_sum_data tracks 64*index delayed exactly 7 cycles, continuous throughput.
REQ-031 Assert i_reset for one cycle mid-ramp -> next edge all outputs 0; first post-reset sample appears 7 cycles after reset deasserts.
REQ-032 i_rvalid held 0 with nonzero data -> results still produced at normal latency.
